// File: rtl/cpu_sequencer_if.sv
// Instruction-ROM and register-file bus between cpu_sequencer (master) and the
// memories around it (slave).
interface cpu_sequencer_if;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic [2:0]  ra1;
  logic [2:0]  ra2;
  logic [7:0]  rd1;
  logic [7:0]  rd2;
  logic [2:0]  wa3;
  logic        we3;
  logic [7:0]  wd3;

  modport master (
    output pc, ra1, ra2, wa3, we3, wd3,
    input  instr, rd1, rd2
  );

  modport slave (
    input  pc, ra1, ra2, wa3, we3, wd3,
    output instr, rd1, rd2
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Four-cycle multi-cycle CPU sequencer (fetch/decode/execute/writeback) driving a ROM and 8x8 regfile.
// Define SEQ_SINGLE_STEP_EN to add the 'step' input: one instruction per rising edge of step.
module cpu_sequencer (
  input  logic              clk,
  input  logic              reset,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  cpu_sequencer_if.master   bus,
  output logic [1:0]        state,
  output logic              halted
);

  // HALT shares the low bits of WRITEBACK so the 2-bit state output reads 3 while halted.
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  result_q, result_d;
  logic        take_q, take_d;
  logic        we3_q, we3_d;
  logic        go;

  logic [3:0]  op;
  logic [2:0]  rd, rs, rt;
  logic [7:0]  imm6_sext, imm8, alu;
  logic        writes_reg;

  assign op        = ir_q[15:12];
  assign rd        = ir_q[11:9];
  assign rs        = ir_q[8:6];
  assign rt        = ir_q[5:3];
  assign imm6_sext = {{2{ir_q[5]}}, ir_q[5:0]};
  assign imm8      = ir_q[7:0];
  assign writes_reg = (op >= 4'd1) && (op <= 4'd7) && (rd != 3'd0);

`ifdef SEQ_SINGLE_STEP_EN
  logic step_prev_q;
  assign go = step & ~step_prev_q;
`else
  assign go = 1'b1;
`endif

  assign bus.pc  = pc_q;
  assign bus.wa3 = rd;
  assign bus.we3 = we3_q;
  assign bus.wd3 = result_q;
  assign state   = state_q[1:0];
  assign halted  = (state_q == S_HALT);

  always_comb begin
    bus.ra1 = rs;
    bus.ra2 = rt;
    if (op == 4'd8) begin
      bus.ra1 = rd;
      bus.ra2 = rs;
    end
  end

  always_comb begin
    alu = 8'h00;
    case (op)
      4'd1:    alu = bus.rd1 + bus.rd2;
      4'd2:    alu = bus.rd1 - bus.rd2;
      4'd3:    alu = bus.rd1 & bus.rd2;
      4'd4:    alu = bus.rd1 | bus.rd2;
      4'd5:    alu = {7'd0, $signed(bus.rd1) < $signed(bus.rd2)};
      4'd6:    alu = bus.rd1 + imm6_sext;
      4'd7:    alu = imm8;
      default: alu = 8'h00;
    endcase
  end

  // Operands are sampled in DECODE; the result and branch decision stay frozen until WRITEBACK.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    result_d = result_q;
    take_d   = take_q;
    we3_d    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (go) begin
          ir_d    = bus.instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        result_d = alu;
        take_d   = (bus.rd1 == bus.rd2);
        state_d  = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (op == 4'hF) begin
          state_d = S_HALT;
        end else begin
          state_d = S_WRITEBACK;
          we3_d   = writes_reg;
        end
      end
      S_WRITEBACK: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 8'd1;
        if (op == 4'd8 && take_q) begin
          pc_d = pc_q + 8'd1 + imm6_sext;
        end else if (op == 4'd9) begin
          pc_d = imm8;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      pc_q        <= 8'd0;
      ir_q        <= 16'd0;
      result_q    <= 8'd0;
      take_q      <= 1'b0;
      we3_q       <= 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      step_prev_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      result_q    <= result_d;
      take_q      <= take_d;
      we3_q       <= we3_d;
`ifdef SEQ_SINGLE_STEP_EN
      step_prev_q <= step;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: instruction-level ISA model checked every cycle, plus directed programs
// with hand-computed writes, pc values and halt behaviour. Honours SEQ_SINGLE_STEP_EN.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state;
  logic       halted;

  cpu_sequencer_if bus ();

`ifdef SEQ_SINGLE_STEP_EN
  logic step;
  logic auto_step;
  logic man_step;
`endif

  cpu_sequencer dut (
    .clk    (clk),
    .reset  (reset),
`ifdef SEQ_SINGLE_STEP_EN
    .step   (step),
`endif
    .bus    (bus),
    .state  (state),
    .halted (halted)
  );

  always #5 clk = ~clk;

  // Environment: combinational ROM and register file that the DUT drives.
  logic [15:0] rom [256];
  logic [7:0]  preset [8];
  logic [7:0]  env_regs [8];
  logic        load_en;

  assign bus.instr = rom[bus.pc];
  assign bus.rd1   = env_regs[bus.ra1];
  assign bus.rd2   = env_regs[bus.ra2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      if (load_en) for (int i = 0; i < 8; i++) env_regs[i] <= preset[i];
    end else if (bus.we3) begin
      env_regs[bus.wa3] <= bus.wd3;
    end
  end

  int cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

`ifdef SEQ_SINGLE_STEP_EN
  // Auto mode raises step in every odd cycle, so each FETCH sees a fresh rising edge.
  always @(posedge clk) begin
    #1;
    step = auto_step ? ~cyc[0] : man_step;
  end
`endif

  int n_cmp;
  int n_bad;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ISA-level result of an instruction given R[rs] and R[rt].
  function automatic logic [7:0] isa_value(input logic [15:0] ir, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] s6;
    s6 = {{2{ir[5]}}, ir[5:0]};
    case (ir[15:12])
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      4'd6:    return a + s6;
      4'd7:    return ir[7:0];
      default: return 8'd0;
    endcase
  endfunction

  // Reference model: executes one whole instruction per four cycles at the ISA level.
  int          m_phase;
  logic [7:0]  m_pc;
  logic        m_halt;
  logic [15:0] m_ir;
  logic        e_wen;
  logic [7:0]  e_wd;
  logic [7:0]  e_npc;
  logic [7:0]  m_regs [8];
`ifdef SEQ_SINGLE_STEP_EN
  logic        m_prev_step;
`endif

  always @(posedge clk or negedge reset) begin
    logic       go;
    logic [3:0] op;
    logic [7:0] s6;
    if (!reset) begin
      m_phase = 0;
      m_pc    = 8'd0;
      m_halt  = 1'b0;
      e_wen   = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      m_prev_step = 1'b0;
`endif
      if (load_en) for (int i = 0; i < 8; i++) m_regs[i] = preset[i];
    end else begin
`ifdef SEQ_SINGLE_STEP_EN
      go = step && !m_prev_step;
      m_prev_step = step;
`else
      go = 1'b1;
`endif
      if (!m_halt) begin
        case (m_phase)
          0: if (go) begin
            m_ir  = rom[m_pc];
            op    = m_ir[15:12];
            s6    = {{2{m_ir[5]}}, m_ir[5:0]};
            e_wd  = isa_value(m_ir, m_regs[m_ir[8:6]], m_regs[m_ir[5:3]]);
            e_wen = (op >= 4'd1) && (op <= 4'd7) && (m_ir[11:9] != 3'd0);
            e_npc = m_pc + 8'd1;
            if (op == 4'd8 && m_regs[m_ir[11:9]] == m_regs[m_ir[8:6]]) e_npc = m_pc + 8'd1 + s6;
            if (op == 4'd9) e_npc = m_ir[7:0];
            m_phase = 1;
          end
          1: m_phase = 2;
          2: begin
            if (m_ir[15:12] == 4'hF) m_halt = 1'b1;
            else m_phase = 3;
          end
          default: begin
            if (e_wen) m_regs[m_ir[11:9]] = e_wd;
            m_pc    = e_npc;
            m_phase = 0;
          end
        endcase
      end
    end
  end

  // Per-cycle compare of every observable output against the model.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check_output("state", state, m_halt ? 3 : m_phase);
      check_output("pc", bus.pc, m_pc);
      check_output("halted", halted, m_halt);
      check_output("we3", bus.we3, (!m_halt && m_phase == 3 && e_wen));
      if (!m_halt && m_phase == 3 && e_wen) begin
        check_output("wa3", bus.wa3, m_ir[11:9]);
        check_output("wd3", bus.wd3, e_wd);
      end
    end
  end

  int cap_cyc[$];
  int cap_wa[$];
  int cap_wd[$];
  int cap_base;
  int exp_cyc[$];
  int exp_wa[$];
  int exp_wd[$];

  always @(negedge clk) begin
    if (reset === 1'b1 && bus.we3 === 1'b1) begin
      cap_cyc.push_back(cyc + 1);
      cap_wa.push_back(int'(bus.wa3));
      cap_wd.push_back(int'(bus.wd3));
    end
  end

  function automatic logic [15:0] enc_reg(input int op, input int rd, input int rs, input int rt);
    return {op[3:0], rd[2:0], rs[2:0], rt[2:0], 3'b000};
  endfunction

  function automatic logic [15:0] enc_imm(input int op, input int rd, input int imm8);
    return {op[3:0], rd[2:0], 1'b0, imm8[7:0]};
  endfunction

  function automatic logic [15:0] enc_ri(input int op, input int rd, input int rs, input int imm6);
    return {op[3:0], rd[2:0], rs[2:0], imm6[5:0]};
  endfunction

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    for (int i = 0; i < 8; i++) preset[i] = 8'd0;
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Hold reset (loading presets), check the reset values, then release between edges.
  task automatic apply_stimulus(input string tag);
    reset   = 1'b0;
    load_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_output({tag, "_rst_state"}, state, 0);
    check_output({tag, "_rst_pc"}, bus.pc, 0);
    check_output({tag, "_rst_we3"}, bus.we3, 0);
    check_output({tag, "_rst_wd3"}, bus.wd3, 0);
    check_output({tag, "_rst_halted"}, halted, 0);
    @(negedge clk);
    #1;
    reset    = 1'b1;
    load_en  = 1'b0;
    cap_base = cap_wa.size();
  endtask

  task automatic wait_halt(input string tag, input int bound);
    int k;
    k = 0;
    while (halted !== 1'b1 && k < bound) begin
      run_edges(1);
      k++;
    end
    if (halted !== 1'b1) check_output({tag, "_halt_timeout"}, halted, 1);
  endtask

  task automatic check_writes(input string tag);
    check_output({tag, "_nwrites"}, cap_wa.size() - cap_base, exp_wa.size());
    for (int k = 0; k < exp_wa.size(); k++) begin
      if (cap_base + k < cap_wa.size()) begin
        check_output({tag, "_wcyc"}, cap_cyc[cap_base + k], exp_cyc[k]);
        check_output({tag, "_wa3"}, cap_wa[cap_base + k], exp_wa[k]);
        check_output({tag, "_wd3"}, cap_wd[cap_base + k], exp_wd[k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b0;
    load_en = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    auto_step = 1'b1;
    man_step  = 1'b0;
`endif

    $display("[TB] LI/LI/ADD program");
    fill_rom();
    rom[0] = enc_imm(7, 1, 5);
    rom[1] = enc_imm(7, 2, 250);
    rom[2] = enc_reg(1, 3, 1, 2);
    apply_stimulus("a");
    run_edges(12);
    check_output("a_pc", bus.pc, 3);
    check_output("a_model_pc", m_pc, 3);
    exp_cyc = '{4, 8, 12};
    exp_wa  = '{1, 2, 3};
    exp_wd  = '{5, 250, 255};
    check_writes("a");

    $display("[TB] BEQ taken / not taken");
    fill_rom();
    rom[0]  = enc_imm(9, 0, 10);
    rom[10] = enc_ri(8, 1, 2, 62);
    preset[1] = 8'd3;
    preset[2] = 8'd3;
    apply_stimulus("b1");
    wait_halt("b1", 40);
    check_output("b1_pc", bus.pc, 9);
    check_output("b1_model_pc", m_pc, 9);
    check_output("b1_no_we3", cap_wa.size() - cap_base, 0);
    preset[2] = 8'd4;
    apply_stimulus("b2");
    wait_halt("b2", 40);
    check_output("b2_pc", bus.pc, 11);
    check_output("b2_no_we3", cap_wa.size() - cap_base, 0);

    $display("[TB] JMP 255 and pc wrap");
    fill_rom();
    rom[0]   = enc_imm(9, 0, 255);
    rom[255] = 16'h0000;
    apply_stimulus("c");
    run_edges(4);
    check_output("c_pc_255", bus.pc, 255);
    check_output("c_model_pc_255", m_pc, 255);
    run_edges(4);
    check_output("c_pc_wrap", bus.pc, 0);

    $display("[TB] SLT/ADDI/LI r0/SUB/OR/AND");
    fill_rom();
    rom[0] = enc_reg(5, 3, 1, 2);
    rom[1] = enc_imm(7, 1, 0);
    rom[2] = enc_ri(6, 4, 1, 63);
    rom[3] = enc_imm(7, 0, 7);
    rom[4] = enc_reg(2, 5, 1, 2);
    rom[5] = enc_reg(4, 6, 3, 4);
    rom[6] = enc_reg(3, 7, 4, 2);
    rom[7] = enc_reg(12, 1, 1, 1);
    preset[1] = 8'h80;
    preset[2] = 8'h01;
    apply_stimulus("d");
    wait_halt("d", 60);
    exp_cyc = '{4, 8, 12, 20, 24, 28};
    exp_wa  = '{3, 1, 4, 5, 6, 7};
    exp_wd  = '{1, 0, 255, 255, 255, 1};
    check_writes("d");
    check_output("d_r0", env_regs[0], 0);
    check_output("d_r4", env_regs[4], 8'hFF);
    for (int i = 0; i < 8; i++) check_output("d_regfile", env_regs[i], m_regs[i]);

    $display("[TB] reset during EXECUTE");
    fill_rom();
    rom[0] = enc_reg(1, 1, 2, 3);
    preset[1] = 8'h11;
    preset[2] = 8'd5;
    preset[3] = 8'd6;
    apply_stimulus("e");
    run_edges(2);
    check_output("e_in_execute", state, 2);
    reset = 1'b0;
    #1;
    check_output("e_async_state", state, 0);
    check_output("e_async_pc", bus.pc, 0);
    check_output("e_async_we3", bus.we3, 0);
    check_output("e_async_wd3", bus.wd3, 0);
    check_output("e_async_halted", halted, 0);
    run_edges(3);
    check_output("e_r1_kept", env_regs[1], 8'h11);
    check_output("e_no_we3", cap_wa.size() - cap_base, 0);

    $display("[TB] HALT at pc 4");
    fill_rom();
    for (int i = 0; i < 4; i++) rom[i] = 16'h0000;
    apply_stimulus("f");
    wait_halt("f", 40);
    run_edges(100);
    check_output("f_pc", bus.pc, 4);
    check_output("f_model_pc", m_pc, 4);
    check_output("f_state", state, 3);
    check_output("f_halted", halted, 1);
    check_output("f_we3", bus.we3, 0);

`ifdef SEQ_SINGLE_STEP_EN
    $display("[TB] single step");
    fill_rom();
    for (int i = 0; i < 4; i++) rom[i] = 16'h0000;
    auto_step = 1'b0;
    man_step  = 1'b0;
    apply_stimulus("g");
    run_edges(10);
    check_output("g_wait_pc", bus.pc, 0);
    check_output("g_wait_state", state, 0);
    man_step = 1'b1;
    run_edges(20);
    check_output("g_held_pc", bus.pc, 1);
    check_output("g_held_state", state, 0);
    man_step = 1'b0;
    run_edges(2);
    man_step = 1'b1;
    run_edges(6);
    check_output("g_second_pc", bus.pc, 2);
    auto_step = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have ports clk input 1 (clock, all state on rising edge) and reset input 1 (reset, asynchronous, active-low).
REQ-002 SHALL have port pc output 8: instruction address to the combinational instruction ROM.
REQ-003 SHALL have port instr input 16: ROM data for the current pc.
REQ-004 SHALL have ports ra1 output 3 and ra2 output 3: register-file read addresses.
REQ-005 SHALL have ports rd1 input 8 and rd2 input 8: register-file read data, combinational from ra1/ra2.
REQ-006 SHALL have ports wa3 output 3, we3 output 1 and wd3 output 8: register-file write port.
REQ-007 SHALL have port state output 2: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3.
REQ-008 SHALL have port halted output 1: high while in HALT.

Function
REQ-009 SHALL hold a 16-bit instruction register IR with fields op=IR[15:12], rd=IR[11:9], rs=IR[8:6], rt=IR[5:3], imm6=IR[5:0], imm8=IR[7:0].
REQ-010 SHALL drive ra1=rs, ra2=rt for op 1-6; ra1=rd, ra2=rs for op 8 (BEQ); wa3=rd at all times.
REQ-011 SHALL run FSM FETCH->DECODE->EXECUTE->WRITEBACK->FETCH, 4 cycles per instruction; IR loads from instr on FETCH exit.
REQ-012 SHALL sample rd1/rd2 in DECODE and register the 8-bit result or branch decision on DECODE exit.
REQ-013 SHALL decode ops: 0 NOP; 1 ADD rd=rs+rt; 2 SUB rd=rs-rt; 3 AND; 4 OR; 5 SLT rd=(signed rs<signed rt)?1:0; 6 ADDI rd=rs+sext(imm6); 7 LI rd=imm8; 8 BEQ if R[rd]==R[rs] branch; 9 JMP pc=imm8; 15 HALT; 10-14 act as NOP.
REQ-014 SHALL compute all arithmetic modulo 256, no carry/overflow output.
REQ-015 SHALL assert we3 for exactly the WRITEBACK cycle of ops 1-7, only when rd!=0; wd3 SHALL hold the result during that cycle.
REQ-016 SHALL update pc on WRITEBACK exit: pc+1 default; BEQ taken pc+1+sext(imm6); JMP imm8; all modulo 256 (255+1 wraps to 0).
REQ-017 SHALL on HALT enter HALT after EXECUTE: pc frozen, we3=0, halted=1, state output=3, left only by reset.
REQ-018 SHALL keep we3 low in FETCH, DECODE, EXECUTE and HALT.

Reset
REQ-019 SHALL on reset low immediately force state=FETCH, pc=0, IR=0, result=0, we3=0, wd3=0, halted=0, independent of clk.
REQ-020 SHALL abort any in-flight instruction on reset with no register write; first fetch from pc=0 on the first rising edge after reset release.

Configuration
REQ-021 SHALL, with SEQ_SINGLE_STEP_EN defined, add input step (1 bit): FSM waits in FETCH until a rising edge of step (registered detect, previous-value register reset to 0), then runs exactly one instruction.
REQ-022 SHALL, without SEQ_SINGLE_STEP_EN, omit port step and free-run per REQ-011.
REQ-023 SHALL ignore step edges outside FETCH; step held high SHALL issue only one instruction.

Verification
REQ-024 Reset mid-EXECUTE of ADD r1 -> state=0, pc=0, we3 never asserted, r1 unchanged.
REQ-025 ROM {LI r1,5; LI r2,250; ADD r3,r1,r2} -> WRITEBACK cycles 4, 8, 12 with wa3/wd3 = 1/5, 2/250, 3/255; pc=3 after cycle 12.
REQ-026 r1=3, r2=3, BEQ r1,r2,-2 at pc=10 -> pc=9; with r2=4 -> pc=11; no we3 pulse.
REQ-027 JMP 255 then NOP at 255 -> pc 255 then wraps to 0.
REQ-028 SLT r3,r1,r2 with r1=0x80, r2=0x01 -> wd3=1; ADDI r4,r1,-1 with r1=0 -> wd3=0xFF; LI r0,7 -> we3 stays 0.
REQ-029 HALT at pc=4 -> halted=1, pc stays 4 for 100 cycles; with SEQ_SINGLE_STEP_EN, step held high 20 cycles runs one instruction only.
